// File: rtl/stack_pkg.sv
// Shared types and helpers for the LIFO stack: operation encoding and pointer sizing.
package stack_pkg;

  // Encoding matches {push, pop} so decode is a direct mapping.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    stack_op_t op;
    unique case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

  // Pointer needs one extra bit so it can represent a completely full stack.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Control and data bundle between a stack user (master) and the LIFO stack (slave).
interface lifo_stack_if
  import stack_pkg::*;
#(
  parameter int unsigned word_width = 8,
  parameter int unsigned depth      = 16
);

  logic                          push;
  logic                          pop;
  logic                          clear_err;
  logic [word_width-1:0]         D_IN;
  logic [word_width-1:0]         D_OUT;
  logic [ptr_width(depth)-1:0]   count;
  logic                          empty;
  logic                          full;
  logic                          overflow;
  logic                          underflow;

  modport master (
    output push, pop, clear_err, D_IN,
    input  D_OUT, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, clear_err, D_IN,
    output D_OUT, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/stack_pointer.sv
// Saturating up/down counter 0..depth with registered empty/full decodes.
module stack_pointer
  import stack_pkg::*;
#(
  parameter int unsigned depth = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inc_i,
  input  logic                        dec_i,
  output logic [ptr_width(depth)-1:0] count_o,
  output logic                        is_empty_o,
  output logic                        is_full_o
);

  localparam int unsigned PtrW = ptr_width(depth);
  localparam logic [PtrW-1:0] MaxCnt = PtrW'(depth);

  logic [PtrW-1:0] cnt_d, cnt_q;
  logic            empty_d, empty_q;
  logic            full_d, full_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + PtrW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - PtrW'(1);
    end
    // Decode from the next count so the flags land in the same cycle as count.
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == MaxCnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign count_o    = cnt_q;
  assign is_empty_o = empty_q;
  assign is_full_o  = full_q;

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with push/pop/replace, registered top-of-stack and sticky error flags.
module lifo_stack
  import stack_pkg::*;
#(
  parameter int unsigned word_width = 8,
  parameter int unsigned depth      = 16
) (
  input logic         clk,
  input logic         reset,
  lifo_stack_if.slave bus
);

  localparam int unsigned PtrW = ptr_width(depth);
  localparam int unsigned IdxW = $clog2(depth);

  stack_op_t             op;
  logic [PtrW-1:0]       sp;
  logic                  sp_empty;
  logic                  sp_full;
  logic                  do_push;
  logic                  do_replace;
  logic                  do_pop;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  mem_we;
  logic [IdxW-1:0]       wr_idx;
  logic [IdxW-1:0]       rd_idx;
  logic [word_width-1:0] mem_q [depth];
  logic [word_width-1:0] dout_d, dout_q;
  logic                  ovf_d, ovf_q;
  logic                  udf_d, udf_q;

  stack_pointer #(
    .depth (depth)
  ) u_stack_pointer (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (do_push),
    .dec_i      (do_pop),
    .count_o    (sp),
    .is_empty_o (sp_empty),
    .is_full_o  (sp_full)
  );

  // Resolve the requested operation against the pre-edge occupancy.
  always_comb begin
    op         = decode_op(bus.push, bus.pop);
    do_push    = 1'b0;
    do_replace = 1'b0;
    do_pop     = 1'b0;
    ovf_evt    = 1'b0;
    udf_evt    = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (sp_full) ovf_evt = 1'b1;
        else         do_push = 1'b1;
      end
      OP_POP: begin
        if (sp_empty) udf_evt = 1'b1;
        else          do_pop  = 1'b1;
      end
      OP_REPLACE: begin
        if (sp_empty) do_push    = 1'b1;
        else          do_replace = 1'b1;
      end
      default: ;
    endcase
  end

  // Indices are only formed when in range: push implies sp < depth, replace/pop imply sp >= 1.
  always_comb begin
    mem_we = do_push | do_replace;
    wr_idx = '0;
    rd_idx = '0;
    if (do_push) begin
      wr_idx = IdxW'(sp);
    end else if (do_replace) begin
      wr_idx = IdxW'(sp - PtrW'(1));
    end
    if (do_pop && (sp > PtrW'(1))) begin
      rd_idx = IdxW'(sp - PtrW'(2));
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (mem_we) begin
      dout_d = bus.D_IN;
    end else if (do_pop) begin
      dout_d = (sp == PtrW'(1)) ? '0 : mem_q[rd_idx];
    end
    // A fresh error outranks a simultaneous clear.
    ovf_d = ovf_evt | (ovf_q & ~bus.clear_err);
    udf_d = udf_evt | (udf_q & ~bus.clear_err);
  end

  // Storage is deliberately left unreset; reads never reach unwritten entries.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= bus.D_IN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign bus.D_OUT     = dout_q;
  assign bus.count     = sp;
  assign bus.empty     = sp_empty;
  assign bus.full      = sp_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

  a_not_full_and_empty : assert property (@(posedge clk) disable iff (!reset)
    !(sp_empty && sp_full));
  a_count_in_range : assert property (@(posedge clk) disable iff (!reset)
    sp <= PtrW'(depth));

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: vector table plus hand-written fill/reset sequences.
module tb_lifo_stack;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

  typedef struct {
    string      name;
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       e;
    logic       f;
    logic       o;
    logic       u;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t tbl[$];

  lifo_stack_if #(.word_width(W), .depth(D)) bus_if ();

  lifo_stack #(
    .word_width (W),
    .depth      (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d);
    bus_if.push      = p;
    bus_if.pop       = q;
    bus_if.clear_err = c;
    bus_if.D_IN      = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] dout, input logic [4:0] cnt,
                             input logic e, input logic f, input logic o, input logic u);
    check({tag, ".dout"}, 32'(bus_if.D_OUT), 32'(dout));
    check({tag, ".count"}, 32'(bus_if.count), 32'(cnt));
    check({tag, ".empty"}, 32'(bus_if.empty), 32'(e));
    check({tag, ".full"}, 32'(bus_if.full), 32'(f));
    check({tag, ".overflow"}, 32'(bus_if.overflow), 32'(o));
    check({tag, ".underflow"}, 32'(bus_if.underflow), 32'(u));
  endtask

  function automatic vec_t mk(input string n, input logic p, input logic q, input logic c,
                              input logic [7:0] din, input logic [7:0] dout,
                              input logic [4:0] cnt, input logic e, input logic f,
                              input logic o, input logic u);
    vec_t v;
    v.name = n; v.push = p; v.pop = q; v.clr = c; v.din = din; v.dout = dout;
    v.cnt = cnt; v.e = e; v.f = f; v.o = o; v.u = u;
    return v;
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus_if.push = 1'b0; bus_if.pop = 1'b0; bus_if.clear_err = 1'b0; bus_if.D_IN = '0;

    //        name         push pop clr din    dout   cnt e f o u
    tbl.push_back(mk("push11",   1, 0, 0, 8'h11, 8'h11, 1, 0, 0, 0, 0));
    tbl.push_back(mk("push22",   1, 0, 0, 8'h22, 8'h22, 2, 0, 0, 0, 0));
    tbl.push_back(mk("push33",   1, 0, 0, 8'h33, 8'h33, 3, 0, 0, 0, 0));
    tbl.push_back(mk("pop1",     0, 1, 0, 8'h00, 8'h22, 2, 0, 0, 0, 0));
    tbl.push_back(mk("pop2",     0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0));
    tbl.push_back(mk("pop3",     0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk("popempty", 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk("popclr",   0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk("clronly",  0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0));
    tbl.push_back(mk("replempty",1, 1, 0, 8'h5A, 8'h5A, 1, 0, 0, 0, 0));
    tbl.push_back(mk("poplast",  0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0));

    #23 reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
    check_state("idle", 8'h00, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din);
      check_state(tbl[i].name, tbl[i].dout, tbl[i].cnt, tbl[i].e, tbl[i].f, tbl[i].o, tbl[i].u);
    end

    // Fill to depth, then exercise overflow and replace-on-full.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(i));
    check_state("fill", 8'h0F, 16, 0, 1, 0, 0);
    step(1, 0, 0, 8'hAA);
    check_state("pushfull", 8'h0F, 16, 0, 1, 1, 0);
    step(0, 1, 0, 8'h00);
    check_state("popafterovf", 8'h0E, 15, 0, 0, 1, 0);
    step(1, 0, 0, 8'h0F);
    check_state("refill", 8'h0F, 16, 0, 1, 1, 0);
    step(0, 0, 1, 8'h00);
    check_state("clrovf", 8'h0F, 16, 0, 1, 0, 0);
    step(1, 1, 0, 8'h77);
    check_state("replfull", 8'h77, 16, 0, 1, 0, 0);
    step(0, 1, 0, 8'h00);
    check_state("popreplfull", 8'h0E, 15, 0, 0, 0, 0);

    // Async reset with no clock edge in between.
    reset = 1'b0;
    #1;
    check_state("rst1", 8'h00, 0, 1, 0, 0, 0);
    #1 reset = 1'b1;

    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(1, 0, 0, 8'h44);
    check_state("four", 8'h44, 4, 0, 0, 0, 0);
    step(1, 1, 0, 8'h99);
    check_state("replace", 8'h99, 4, 0, 0, 0, 0);
    step(0, 1, 0, 8'h00);
    check_state("popreplace", 8'h33, 3, 0, 0, 0, 0);
    step(1, 0, 0, 8'h44);
    step(1, 0, 0, 8'h55);
    check_state("five", 8'h55, 5, 0, 0, 0, 0);

    // Reset mid-stream with a push pending: clears at once and the edge under reset is ignored.
    bus_if.push = 1'b1; bus_if.D_IN = 8'hEE;
    #2 reset = 1'b0;
    #1;
    check_state("rst2", 8'h00, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_state("rst2hold", 8'h00, 0, 1, 0, 0, 0);
    #2 reset = 1'b1;
    step(0, 0, 0, 8'h00);
    check_state("rst2rel", 8'h00, 0, 1, 0, 0, 0);
    step(1, 0, 0, 8'hC3);
    check_state("afterrst", 8'hC3, 1, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
